// File: rtl/integer_unit_pkg.sv
// integer_unit_pkg: shared types, default latencies and unit helpers for the integer issue stage.
package integer_unit_pkg;
    typedef enum logic [1:0] {UNIT_ALU = 2'd0, UNIT_BMU = 2'd1, UNIT_MUL = 2'd2, UNIT_DIV = 2'd3} iexu_unit_t;
    typedef logic [3:0]  iexu_valid_t;
    typedef logic [4:0]  iexu_uop_t;
    typedef logic [31:0] data_word_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
    } instr_packet_t;

    localparam int ALU_LATENCY     = 0;
    localparam int BMU_LATENCY_DEF = 1;
    localparam int MUL_LATENCY_DEF = 4;
    localparam int DIV_LATENCY_DEF = 34;

    function automatic int unit_latency(iexu_unit_t u, int bmu_lat, int mul_lat, int div_lat);
        return u == UNIT_ALU ? ALU_LATENCY : u == UNIT_BMU ? bmu_lat : u == UNIT_MUL ? mul_lat : div_lat;
    endfunction

    function automatic iexu_valid_t unit_onehot(iexu_unit_t u);
        return iexu_valid_t'(1) << u;
    endfunction
endpackage

// File: rtl/writeback_reservation_table.sv
// writeback_reservation_table: shift register of future result-bus occupancy; bit k busy k cycles ahead.
module writeback_reservation_table #(
    parameter int DEPTH = 36
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_i,
    input  logic                     set_i,
    input  logic [$clog2(DEPTH)-1:0] lat_i,
    output logic                     slot_free_o
);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0] rsv_q, rsv_d;

    // The slot a new op would hit is one further out, since the table shifts on the same edge.
    assign slot_free_o = !rsv_q[lat_i + IW'(1)];
    assign rsv_d       = (rsv_q >> 1) | (DEPTH'(set_i) << lat_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rsv_q <= '0;
        else if (en_i) rsv_q <= rsv_d;
    end
endmodule

// File: rtl/integer_issue_stage.sv
// integer_issue_stage: registers one decoded op per cycle into the integer execution unit,
// stalling any op whose result would collide on the shared result bus or hit a busy divider.
module integer_issue_stage
    import integer_unit_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int BMU_LATENCY = BMU_LATENCY_DEF,
    parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clk_en_i,
    input  logic          flush_i,
    input  logic          issue_valid_i,
    output logic          issue_ready_o,
    input  iexu_unit_t    unit_i,
    input  iexu_uop_t     operation_i,
    input  instr_packet_t ipacket_i,
    input  data_word_t    operand_1_i,
    input  data_word_t    operand_2_i,
    input  logic          div_idle_i,
    output iexu_valid_t   data_valid_o,
    output iexu_uop_t     operation_o,
    output instr_packet_t ipacket_o,
    output data_word_t    operand_1_o,
    output data_word_t    operand_2_o
);
    localparam int DEPTH = DIV_LATENCY + 2;
    localparam int IW    = $clog2(DEPTH);

    logic [IW-1:0] lat;
    logic          slot_free, div_free, accept;
    iexu_valid_t   data_valid_q, data_valid_d;
    iexu_uop_t     operation_q, operation_d;
    instr_packet_t ipacket_q, ipacket_d;
    data_word_t    operand_1_q, operand_1_d, operand_2_q, operand_2_d;
    logic          div_launch_q, div_launch_d;

    assign lat           = IW'(unit_latency(unit_i, BMU_LATENCY, MUL_LATENCY, DIV_LATENCY));
    // div_idle_i lags the launch by a cycle, so the launch flag masks that window.
    assign div_free      = div_idle_i & !div_launch_q;
    assign issue_ready_o = clk_en_i & !flush_i & slot_free & ((unit_i != UNIT_DIV) | div_free);
    assign accept        = issue_valid_i & issue_ready_o;

    writeback_reservation_table #(.DEPTH(DEPTH)) u_rsv (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (clk_en_i),
        .set_i       (accept),
        .lat_i       (lat),
        .slot_free_o (slot_free)
    );

    always_comb begin
        data_valid_d = accept ? unit_onehot(unit_i) : '0;
        operation_d  = accept ? operation_i : operation_q;
        ipacket_d    = accept ? ipacket_i : ipacket_q;
        operand_1_d  = accept ? operand_1_i : operand_1_q;
        operand_2_d  = accept ? operand_2_i : operand_2_q;
        div_launch_d = accept & (unit_i == UNIT_DIV);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_valid_q <= '0;
            operation_q  <= '0;
            ipacket_q    <= '0;
            operand_1_q  <= '0;
            operand_2_q  <= '0;
            div_launch_q <= 1'b0;
        end else if (clk_en_i) begin
            data_valid_q <= data_valid_d;
            operation_q  <= operation_d;
            ipacket_q    <= ipacket_d;
            operand_1_q  <= operand_1_d;
            operand_2_q  <= operand_2_d;
            div_launch_q <= div_launch_d;
        end
    end

    assign data_valid_o = data_valid_q;
    assign operation_o  = operation_q;
    assign ipacket_o    = ipacket_q;
    assign operand_1_o  = operand_1_q;
    assign operand_2_o  = operand_2_q;
endmodule

// File: tb/tb_integer_issue_stage.sv
// tb_integer_issue_stage: directed and mixed stimulus against a timeline model of result-bus occupancy.
module tb_integer_issue_stage;
    import integer_unit_pkg::*;

    localparam int MUL_L = 4;
    localparam int BMU_L = 1;
    localparam int DIV_L = 34;

    logic          clk = 1'b0;
    logic          rst_n, clk_en, flush, valid, div_idle;
    logic          ready;
    iexu_unit_t    unit;
    iexu_uop_t     op, op_o;
    instr_packet_t pkt, pkt_o;
    data_word_t    a, b, a_o, b_o;
    iexu_valid_t   dv;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    integer_issue_stage #(.MUL_LATENCY(MUL_L), .BMU_LATENCY(BMU_L), .DIV_LATENCY(DIV_L)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .clk_en_i      (clk_en),
        .flush_i       (flush),
        .issue_valid_i (valid),
        .issue_ready_o (ready),
        .unit_i        (unit),
        .operation_i   (op),
        .ipacket_i     (pkt),
        .operand_1_i   (a),
        .operand_2_i   (b),
        .div_idle_i    (div_idle),
        .data_valid_o  (dv),
        .operation_o   (op_o),
        .ipacket_o     (pkt_o),
        .operand_1_o   (a_o),
        .operand_2_o   (b_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: absolute timeline of result-bus cycles, indexed by enabled-edge count.
    bit            busy[int];
    int            e = 0;
    bit            last_div = 0;
    logic [3:0]    exp_dv = '0;
    logic [4:0]    exp_op = '0;
    logic [36:0]   exp_pkt = '0;
    logic [31:0]   exp_a = '0, exp_b = '0;
    logic          m_ready, m_acc;

    function automatic int m_lat(iexu_unit_t u);
        return u == UNIT_ALU ? 0 : u == UNIT_BMU ? BMU_L : u == UNIT_MUL ? MUL_L : DIV_L;
    endfunction

    function automatic bit is_busy(int slot);
        return busy.exists(slot) && busy[slot];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busy.delete();
            last_div = 0;
            exp_dv = '0; exp_op = '0; exp_pkt = '0; exp_a = '0; exp_b = '0;
        end
        chk("dv", 64'(dv), 64'(exp_dv));
        chk("op", 64'(op_o), 64'(exp_op));
        chk("pkt", 64'(pkt_o), 64'(exp_pkt));
        chk("opa", 64'(a_o), 64'(exp_a));
        chk("opb", 64'(b_o), 64'(exp_b));
        m_ready = clk_en && !flush && !is_busy(e + 1 + m_lat(unit))
                  && (unit != UNIT_DIV || (div_idle && !last_div));
        chk("ready", 64'(ready), 64'(m_ready));
        if (rst_n && clk_en) begin
            m_acc = valid && m_ready;
            if (m_acc) begin
                busy[e + 1 + m_lat(unit)] = 1;
                exp_op = op; exp_pkt = pkt; exp_a = a; exp_b = b;
            end
            exp_dv = m_acc ? (4'b0001 << unit) : 4'b0000;
            last_div = m_acc && unit == UNIT_DIV;
            e++;
        end
    end

    task automatic put(input logic v, input iexu_unit_t u);
        valid = v;
        unit = u;
        op = 5'($urandom);
        pkt = {32'($urandom), 5'($urandom)};
        a = $urandom;
        b = $urandom;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; div_idle = 1'b1;
        put(1'b0, UNIT_ALU);
        #2;
        chk("rst_dv", 64'(dv), 64'h0);
        chk("rst_opa", 64'(a_o), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back ALU
        for (int i = 0; i < 6; i++) begin
            put(1'b1, UNIT_ALU);
            #1 chk("alu_rdy", 64'(ready), 64'h1);
            tick;
            chk("alu_dv", 64'(dv), 64'h1);
        end
        put(1'b0, UNIT_ALU); tick;

        // MUL then ALU landing on the same bus cycle
        put(1'b1, UNIT_MUL);
        tick;
        chk("mul_dv", 64'(dv), 64'h4);
        repeat (3) begin put(1'b0, UNIT_ALU); tick; end
        put(1'b1, UNIT_ALU);
        #1 chk("alu_after_mul", 64'(ready), 64'h0);
        tick;
        chk("alu_stall_dv", 64'(dv), 64'h0);
        chk("alu_retry", 64'(ready), 64'h1);
        tick;
        chk("alu_retry_dv", 64'(dv), 64'h1);
        put(1'b0, UNIT_ALU); tick;

        // Second DIV held off by the launch flag, then by div_idle
        put(1'b1, UNIT_DIV);
        #1 chk("div1_rdy", 64'(ready), 64'h1);
        tick;
        chk("div1_dv", 64'(dv), 64'h8);
        put(1'b1, UNIT_DIV);
        #1 chk("div2_launch", 64'(ready), 64'h0);
        tick;
        div_idle = 1'b0;
        #1 chk("div2_busy", 64'(ready), 64'h0);
        repeat (3) tick;
        div_idle = 1'b1;
        #1 chk("div2_go", 64'(ready), 64'h1);
        tick;
        chk("div2_dv", 64'(dv), 64'h8);
        put(1'b0, UNIT_ALU);
        repeat (40) tick;

        // Flush after BMU: valid drops, reservations survive
        put(1'b1, UNIT_MUL); tick;
        put(1'b1, UNIT_BMU);
        #1 chk("bmu_rdy", 64'(ready), 64'h1);
        tick;
        chk("bmu_dv", 64'(dv), 64'h2);
        put(1'b1, UNIT_ALU);
        flush = 1'b1;
        #1 chk("flush_rdy", 64'(ready), 64'h0);
        tick;
        chk("flush_dv", 64'(dv), 64'h0);
        chk("flush_rsv", 64'(dut.u_rsv.rsv_q[2:0]), 64'h5);
        flush = 1'b0;
        put(1'b1, UNIT_ALU);
        #1 chk("post_flush_rdy", 64'(ready), 64'h1);
        tick;
        put(1'b1, UNIT_ALU);
        #1 chk("mul_kept", 64'(ready), 64'h0);
        tick;
        put(1'b0, UNIT_ALU); tick;

        // Clock enable low freezes everything
        put(1'b1, UNIT_MUL); tick;
        clk_en = 1'b0;
        put(1'b1, UNIT_ALU);
        #1 chk("clken_rdy", 64'(ready), 64'h0);
        repeat (3) begin
            tick;
            chk("clken_dv", 64'(dv), 64'h4);
            chk("clken_rsv", 64'(dut.u_rsv.rsv_q[5:0]), 64'h10);
        end
        clk_en = 1'b1;
        put(1'b0, UNIT_ALU);
        repeat (3) tick;
        put(1'b1, UNIT_ALU);
        #1 chk("clken_resume", 64'(ready), 64'h0);
        tick;
        put(1'b0, UNIT_ALU); tick;

        // Asynchronous reset while a DIV is pending
        put(1'b1, UNIT_DIV); tick;
        chk("div3_dv", 64'(dv), 64'h8);
        put(1'b0, UNIT_ALU);
        div_idle = 1'b0;
        rst_n = 1'b0;
        #1 chk("rst_async_dv", 64'(dv), 64'h0);
        chk("rst_async_rsv", 64'(dut.u_rsv.rsv_q), 64'h0);
        tick;
        rst_n = 1'b1;
        div_idle = 1'b1;
        put(1'b1, UNIT_DIV);
        #1 chk("div_after_rst", 64'(ready), 64'h1);
        tick;
        chk("div_after_rst_dv", 64'(dv), 64'h8);

        // Mixed traffic checked by the model alone
        for (int i = 0; i < 80; i++) begin
            put(1'($urandom_range(0, 1)), iexu_unit_t'($urandom_range(0, 3)));
            div_idle = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 7) == 0;
            clk_en = $urandom_range(0, 7) != 0;
            tick;
        end
        flush = 1'b0; clk_en = 1'b1; div_idle = 1'b1;
        put(1'b0, UNIT_ALU);
        repeat (3) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
